// File: rtl/mult_pkg.sv
// Shared definitions for the CPU54 multi-cycle multiplier (seq_mult).
// The optional MULTU support is selected by the SIGNED_SEL_EN macro.
package mult_pkg;

  localparam int MULT_W = 32;
  localparam int CNT_W  = $clog2(MULT_W) + 1;

  typedef enum logic [0:0] {
    M_IDLE,
    M_RUN
  } mult_state_t;

endpackage

// File: rtl/seq_mult_if.sv
// Request/response bundle between the pipeline and seq_mult.
// The optional is_signed select exists only when SIGNED_SEL_EN is defined.
interface seq_mult_if #(
  parameter int WIDTH = 32
);
  import mult_pkg::*;

  // Handshake: start is a level request that is sampled only on an edge
  // where busy=0. That edge launches a run and busy stays high for WIDTH
  // cycles. done pulses for exactly one cycle when z is updated. A start
  // seen while busy=1 is dropped, not queued.
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               start;
  logic [2*WIDTH-1:0] z;
  logic               busy;
  logic               done;
  mult_state_t        state;

`ifdef SIGNED_SEL_EN
  logic               is_signed;

  modport master (output a, b, start, is_signed, input z, busy, done, state);
  modport slave  (input a, b, start, is_signed, output z, busy, done, state);
`else
  modport master (output a, b, start, input z, busy, done, state);
  modport slave  (input a, b, start, output z, busy, done, state);
`endif

endinterface

// File: rtl/twos_abs.sv
// Magnitude and sign of one two's-complement operand.
// The most negative value maps to 2^(WIDTH-1), which is correct when read as unsigned.
module twos_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] mag,
  output logic             neg
);

  assign neg = value[WIDTH-1];
  assign mag = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/seq_mult.sv
// Multi-cycle WIDTHxWIDTH -> 2*WIDTH signed shift-add multiplier (MULT, plus MULTU
// when SIGNED_SEL_EN is defined); same start/busy handshake as the divider.
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input logic        clock,
  input logic        reset,
  seq_mult_if.slave  bus
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  mult_state_t        state;
  mult_state_t        state_next;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH:0]   acc;
  logic               sign;
  logic [2*WIDTH-1:0] z;
  logic               done;

  logic               load;
  logic               step;
  logic               finish;

  // Operand conditioning for the launch edge
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               a_neg;
  logic               b_neg;
  logic               use_sign;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               launch_sign;

  twos_abs #(.WIDTH(WIDTH)) u_abs_a (.value(bus.a), .mag(a_mag), .neg(a_neg));
  twos_abs #(.WIDTH(WIDTH)) u_abs_b (.value(bus.b), .mag(b_mag), .neg(b_neg));

`ifdef SIGNED_SEL_EN
  assign use_sign = bus.is_signed;
`else
  assign use_sign = 1'b1;
`endif

  assign op_a        = use_sign ? a_mag : bus.a;
  assign op_b        = use_sign ? b_mag : bus.b;
  assign launch_sign = use_sign & (a_neg ^ b_neg);

  // One shift-add iteration; the W+1-bit high half absorbs the carry.
  logic [WIDTH:0]     sum_hi;
  logic [2*WIDTH:0]   acc_next;
  logic [2*WIDTH-1:0] product;

  always_comb begin
    sum_hi   = acc[2*WIDTH:WIDTH] + {1'b0, mcand & {WIDTH{mplier[0]}}};
    acc_next = {1'b0, sum_hi, acc[WIDTH-1:1]};
    product  = acc_next[2*WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= M_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      M_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = M_RUN;
        end
      end
      M_RUN: begin
        step = 1'b1;
        if (count == LAST) begin
          finish     = 1'b1;
          state_next = M_IDLE;
        end
      end
      default: state_next = M_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sign   <= 1'b0;
      z      <= '0;
      done   <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        mcand  <= op_a;
        mplier <= op_b;
        acc    <= '0;
        count  <= '0;
        sign   <= launch_sign;
      end
      if (step) begin
        acc    <= acc_next;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
      end
      // Negating zero yields zero, so no special case is needed here.
      if (finish) begin
        z <= sign ? -product : product;
      end
    end
  end

  assign bus.z     = z;
  assign bus.busy  = (state == M_RUN);
  assign bus.done  = done;
  assign bus.state = state;

endmodule

// File: tb/tb_seq_mult.sv
// Directed and random bench for seq_mult with a scoreboard of expected products.
// Covers the is_signed select when SIGNED_SEL_EN is defined.
module tb_seq_mult;
  import mult_pkg::*;

  localparam int W = MULT_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(W)) bus ();
  seq_mult #(.WIDTH(W)) dut (.clock(clk), .reset(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int launch_cyc = 0;
  logic [2*W-1:0] exp_q[$];

  logic [W-1:0] dir_a[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                             32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
  logic [W-1:0] dir_b[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'h0000_0001, 32'h8000_0000};

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sgn);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    if (sgn) begin
      ea = {{W{a[W-1]}}, a};
      eb = {{W{b[W-1]}}, b};
    end else begin
      ea = {{W{1'b0}}, a};
      eb = {{W{1'b0}}, b};
    end
    return ea * eb;
  endfunction

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    bus.a = a;
    bus.b = b;
`ifdef SIGNED_SEL_EN
    bus.is_signed = sgn;
`endif
  endtask

  task automatic launch(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn);
    @(negedge clk);
    drive(a, b, sgn);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    launch_cyc = cyc;
    bus.start  = 1'b0;
    exp_q.push_back(model(a, b, sgn));
    check({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int   n       = 0;
    int   bad_run = 0;
    logic seen    = 1'b0;
    while (!seen && n < W + 8) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) seen = 1'b1;
      else if (bus.busy !== 1'b1) bad_run++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_held"}, 64'(bad_run), 64'd0);
    if (seen) begin
      check({tag, "_latency"}, 64'(cyc - launch_cyc), 64'(W));
      check({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
      check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check({tag, "_z"}, bus.z, exp_q.pop_front());
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic done_low(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    drive('0, '0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_z", bus.z, 64'd0);
    check("rst_state", 64'(bus.state), 64'(M_IDLE));
    rst = 1'b0;

    // 3 * -4
    launch("t1", 32'd3, 32'hFFFF_FFFC, 1'b1);
    wait_done("t1");
    done_low("t1");

    for (int i = 0; i < 6; i++) begin
      launch($sformatf("dir%0d", i), dir_a[i], dir_b[i], 1'b1);
      wait_done($sformatf("dir%0d", i));
      done_low($sformatf("dir%0d", i));
    end

    // Operand change and start pulse at cycle 10 of a run must not disturb it
    launch("mid", 32'd5, 32'd7, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    drive(32'h1234_5678, 32'hDEAD_BEEF, 1'b1);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("mid_busy", 64'(bus.busy), 64'd1);
    wait_done("mid");
    done_low("mid");

    // Start held high relaunches on the edge after done
    @(negedge clk);
    drive(32'd11, 32'hFFFF_FFF7, 1'b1);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    launch_cyc = cyc;
    exp_q.push_back(model(32'd11, 32'hFFFF_FFF7, 1'b1));
    exp_q.push_back(model(32'd11, 32'hFFFF_FFF7, 1'b1));
    wait_done("held1");
    @(posedge clk);
    #1;
    launch_cyc = cyc;
    check("held_relaunch_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    wait_done("held2");
    done_low("held2");

    // Asynchronous reset in the middle of a run
    launch("rst_mid", 32'h0000_1234, 32'h0000_5678, 1'b1);
    repeat (14) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_z", bus.z, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    launch("post_rst", 32'hFFFF_0001, 32'h0001_0003, 1'b1);
    wait_done("post_rst");
    done_low("post_rst");

    for (int i = 0; i < 6; i++) begin
      logic sgn;
`ifdef SIGNED_SEL_EN
      sgn = 1'($urandom_range(0, 1));
`else
      sgn = 1'b1;
`endif
      launch($sformatf("rnd%0d", i), $urandom, $urandom, sgn);
      wait_done($sformatf("rnd%0d", i));
    end

`ifdef SIGNED_SEL_EN
    launch("multu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("multu");
    launch("mults", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("mults");
    launch("multu_big", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    wait_done("multu_big");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
